feature_packer: RTL

FEATURE_PACKER -- requirements
Module: feature_packer

---
 rtl/wrd_pkg.sv | 23 ++
 rtl/sat_quant.sv | 37 +++
 rtl/feature_packer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wrd_pkg.sv
// Shared word-recognition pipeline package: front-end constants plus the
// default geometry of the feature packer that sits behind the MFCC stage.
package wrd_pkg;

  // Front-end pipeline constants
  localparam int WRD_SAMPLE_RATE = 16000;
  localparam int WRD_FFT_LEN     = 512;
  localparam int WRD_NUM_MEL     = 40;

  // Feature packer defaults
  localparam int FP_I_BW       = 16;  // signed MFCC coefficient width
  localparam int FP_O_BW       = 8;   // signed quantized element width
  localparam int FP_VECTOR_LEN = 13;  // coefficients per packed vector
  localparam int FP_FRAME_LEN  = 50;  // vectors per frame
  localparam int FP_SHIFT      = 4;   // arithmetic right shift before saturation
  localparam int FP_SAT_CNT_W  = 16;  // width of the optional saturation counter

  // Counter width that stays legal for a depth of one
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sat_quant.sv
// Combinational quantizer: floor arithmetic right shift followed by
// saturation to the signed O_BW range. Flags when clamping occurred.
module sat_quant #(
  parameter int I_BW  = 16,
  parameter int O_BW  = 8,
  parameter int SHIFT = 4
) (
  input  logic [I_BW-1:0] data,
  output logic [O_BW-1:0] q,
  output logic            sat
);

  localparam int Q_MAX = 2 ** (O_BW - 1) - 1;
  localparam int Q_MIN = -(2 ** (O_BW - 1));

  logic signed [I_BW-1:0] shifted;
  int                     shifted_int;

  // Shift (floor, no rounding) then clamp to the output range
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    q           = '0;
    sat         = 1'b0;
    shifted     = $signed(data) >>> SHIFT;
    shifted_int = int'(shifted);
    if (shifted_int > Q_MAX) begin
      q   = O_BW'(Q_MAX);
      sat = 1'b1;
    end else if (shifted_int < Q_MIN) begin
      q   = O_BW'(Q_MIN);
      sat = 1'b1;
    end else begin
      q   = shifted[O_BW-1:0];
    end
  end

endmodule

// File: rtl/feature_packer.sv
// Feature packer: quantizes a stream of signed MFCC coefficients and packs
// VECTOR_LEN of them into one output vector, flagging the last vector of
// each FRAME_LEN-vector frame. Optional build macro FEATURE_PACKER_SAT_CNT_EN
// adds sat_cnt_o, a per-frame count of saturated coefficients.
module feature_packer
  import wrd_pkg::*;
#(
  parameter int I_BW       = FP_I_BW,
  parameter int O_BW       = FP_O_BW,
  parameter int VECTOR_LEN = FP_VECTOR_LEN,
  parameter int FRAME_LEN  = FP_FRAME_LEN,
  parameter int SHIFT      = FP_SHIFT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [I_BW-1:0]            data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [O_BW*VECTOR_LEN-1:0] data_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i
`ifdef FEATURE_PACKER_SAT_CNT_EN
  ,
  output logic [FP_SAT_CNT_W-1:0]    sat_cnt_o
`endif
);

  localparam int CW = cnt_width(VECTOR_LEN);
  localparam int VW = cnt_width(FRAME_LEN);

  logic [CW-1:0]              coef_cnt;
  logic [VW-1:0]              vec_cnt;
  logic [O_BW-1:0]            asm_q [VECTOR_LEN];
  logic [O_BW*VECTOR_LEN-1:0] vec_next;
  logic [O_BW-1:0]            q;
  logic                       sat;
  logic                       coef_last;
  logic                       vec_last;
  logic                       accept;
  logic                       load;
  logic                       drain;

  sat_quant #(
    .I_BW  (I_BW),
    .O_BW  (O_BW),
    .SHIFT (SHIFT)
  ) u_sat_quant (
    .data (data_i),
    .q    (q),
    .sat  (sat)
  );

  // Handshake decode: stall input only when the final coefficient would
  // need an output register that is still full and not draining.
  always_comb begin
    coef_last = (coef_cnt == CW'(VECTOR_LEN - 1));
    vec_last  = (vec_cnt == VW'(FRAME_LEN - 1));
    ready_o   = !(coef_last && valid_o && !ready_i);
    accept    = valid_i && ready_o;
    load      = accept && coef_last;
    drain     = valid_o && ready_i;
  end

  // Completed vector: stored slots plus the coefficient arriving this cycle
  always_comb begin
    vec_next = '0;
    for (int k = 0; k < VECTOR_LEN; k++) begin
      vec_next[k*O_BW +: O_BW] = (k == VECTOR_LEN - 1) ? q : asm_q[k];
    end
  end

  // Assembly register and coefficient slot counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      coef_cnt <= '0;
      // NOTE: this array is a handful of flops, not a RAM, so it is reset to give a clean restart.
      for (int k = 0; k < VECTOR_LEN; k++) begin
        asm_q[k] <= '0;
      end
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      asm_q[coef_cnt] <= q;
      coef_cnt        <= coef_last ? '0 : coef_cnt + 1'b1;
    end
  end

  // Output register, frame position and last flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      vec_cnt <= '0;
    end else if (load) begin
      data_o  <= vec_next;
      valid_o <= 1'b1;
      last_o  <= vec_last;
      vec_cnt <= vec_last ? '0 : vec_cnt + 1'b1;
    end else if (drain) begin
      valid_o <= 1'b0;
    end
  end

`ifdef FEATURE_PACKER_SAT_CNT_EN
  logic frame_start;

  always_comb begin
    frame_start = (coef_cnt == '0) && (vec_cnt == '0);
  end

  // Per-frame saturation count, restarted by the first accept of a frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_cnt_o <= '0;
    end else if (accept) begin
      if (frame_start) begin
        sat_cnt_o <= FP_SAT_CNT_W'(sat);
      end else if (sat && (sat_cnt_o != '1)) begin
        sat_cnt_o <= sat_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
